// File: rtl/cpu_oci_trace_packer_pkg.sv
// cpu_oci_trace_pkg: shared state encoding and width helper for the OCI trace packer
package cpu_oci_trace_pkg;
   typedef enum logic [1:0] {RUN, FLUSH, DRAIN, ENDED} state_t;
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction
endpackage

// File: rtl/cpu_oci_trace_packer_if.sv
// cpu_oci_trace_packer_if: trace frame input and FIFO read port of the trace packer
interface cpu_oci_trace_packer_if #(
   parameter int FRAME_W = 2,
   parameter int BUF_W   = 30,
   parameter int CNT_W   = 4
);
   logic               trace_valid;
   logic [FRAME_W-1:0] trace_frame;
   logic               rd_valid;
   logic               rd_ready;
   logic [BUF_W-1:0]   rd_data;
   logic [CNT_W-1:0]   rd_count;
   modport master (output trace_valid, trace_frame, rd_ready, input rd_valid, rd_data, rd_count);
   modport slave  (input trace_valid, trace_frame, rd_ready, output rd_valid, rd_data, rd_count);
endinterface

// File: rtl/cpu_oci_trace_packer_fifo.sv
// cpu_oci_trace_fifo: show-ahead word FIFO that drops pushes into a full queue unless a pop frees a slot
module cpu_oci_trace_fifo import cpu_oci_trace_pkg::*; #(
   parameter int W      = 34,
   parameter int DEPTH  = 4,
   parameter int DROP_W = 8,
   parameter int LVL_W  = cnt_w(DEPTH)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              push,
   input  logic [W-1:0]      din,
   input  logic              rd_ready,
   output logic              rd_valid,
   output logic [W-1:0]      dout,
   output logic [LVL_W-1:0]  level,
   output logic              overflow,
   output logic [DROP_W-1:0] drop_count
);
   localparam int PTR_W = $clog2(DEPTH);
   logic [W-1:0]     mem [DEPTH];
   logic [PTR_W-1:0] wp, rp;
   logic             pop, full, accept, drop;
   assign rd_valid = level != '0;
   assign pop      = rd_valid && rd_ready;
   assign full     = level == LVL_W'(DEPTH);
   assign accept   = push && (!full || pop);
   assign drop     = push && full && !pop;
   assign dout     = mem[rp];
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wp         <= '0;
         rp         <= '0;
         level      <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (accept) begin
            mem[wp] <= din;
            wp      <= wp + 1'b1;
         end
         if (pop) rp <= rp + 1'b1;
         level <= level + LVL_W'(accept) - LVL_W'(pop);
         if (drop) begin
            overflow   <= 1'b1;
            drop_count <= drop_count + DROP_W'(drop_count != '1);
         end
      end
   end
endmodule

// File: rtl/cpu_oci_trace_packer.sv
// cpu_oci_trace_packer: packs trace frames into tagged words, queues them and runs the end-of-test flush/drain
module cpu_oci_trace_packer import cpu_oci_trace_pkg::*; #(
   parameter int FRAME_W         = 2,
   parameter int FRAMES_PER_WORD = 15,
   parameter int DEPTH           = 4,
   parameter int DROP_W          = 8,
   parameter int BUF_W           = FRAME_W * FRAMES_PER_WORD,
   parameter int CNT_W           = cnt_w(FRAMES_PER_WORD),
   parameter int LVL_W           = cnt_w(DEPTH)
) (
   input  logic                     clk,
   input  logic                     reset_n,
   cpu_oci_trace_packer_if.slave    bus,
   input  logic                     test_ending,
   output logic [BUF_W-1:0]         dct_buffer,
   output logic [CNT_W-1:0]         dct_count,
   output logic [LVL_W-1:0]         fifo_level,
   output logic                     overflow,
   output logic [DROP_W-1:0]        drop_count,
   output logic                     test_has_ended
);
   state_t                   state;
   logic                     take, push, pop;
   logic [BUF_W-1:0]         nbuf;
   logic [BUF_W+CNT_W-1:0]   din, head;
   always_comb begin
      take = state == RUN && bus.trace_valid;
      nbuf = dct_buffer;
      nbuf[dct_count*FRAME_W +: FRAME_W] = bus.trace_frame;
      push = (take && dct_count == CNT_W'(FRAMES_PER_WORD - 1)) || (state == FLUSH && dct_count != '0);
      din  = state == FLUSH ? {dct_buffer, dct_count} : {nbuf, CNT_W'(FRAMES_PER_WORD)};
   end
   assign pop = bus.rd_valid && bus.rd_ready;
   assign {bus.rd_data, bus.rd_count} = head;
   cpu_oci_trace_fifo #(.W(BUF_W + CNT_W), .DEPTH(DEPTH), .DROP_W(DROP_W), .LVL_W(LVL_W)) u_fifo (
      .clk        (clk),
      .reset_n    (reset_n),
      .push       (push),
      .din        (din),
      .rd_ready   (bus.rd_ready),
      .rd_valid   (bus.rd_valid),
      .dout       (head),
      .level      (fifo_level),
      .overflow   (overflow),
      .drop_count (drop_count)
   );
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= RUN;
         dct_buffer     <= '0;
         dct_count      <= '0;
         test_has_ended <= 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (take) begin
                  dct_buffer <= push ? '0 : nbuf;
                  dct_count  <= push ? '0 : dct_count + 1'b1;
               end
               if (test_ending) state <= FLUSH;
            end
            FLUSH: begin
               dct_buffer <= '0;
               dct_count  <= '0;
               state      <= DRAIN;
            end
            // empty once this cycle's pop (if any) has taken the last entry
            DRAIN: if (fifo_level == '0 || (fifo_level == LVL_W'(1) && pop)) begin
               state          <= ENDED;
               test_has_ended <= 1'b1;
            end
            ENDED: ;
            default: state <= RUN;
         endcase
      end
   end
endmodule
